// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues one instruction-memory read at a time,
// buffers returned words with their addresses in a two-entry FIFO and hands
// them to decode, with redirects (taken branches/jumps) flushing the buffer.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DROP
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] dropAddr_q, dropAddr_d;
    logic [1:0]  count_q, count_d;
    logic        rdPtr_q, rdPtr_d;
    logic        wrPtr_q, wrPtr_d;
    logic [31:0] bufWord_q [2];
    logic [31:0] bufPc_q [2];

    logic        doPush;
    logic        doPop;
    logic        doFlush;
    logic [1:0]  postPushCount;
    logic [31:0] redirectTarget;

    // Redirect targets are always word aligned; the low two bits are dropped.
    assign redirectTarget = redirect_pc_i & 32'hFFFF_FFFC;

    // A request is on the bus in REQ and DROP. In DROP the PC may already hold
    // a redirect target, so the address of the abandoned request is held
    // separately until its acknowledge retires it.
    assign imem_req_o  = (state_q == REQ) || (state_q == DROP);
    assign imem_addr_o = (state_q == DROP) ? dropAddr_q : pc_q;

    // Head of the buffer drives decode; outputs read zero while empty.
    assign instr_valid_o = (count_q != 2'd0);
    assign instr_o       = instr_valid_o ? bufWord_q[rdPtr_q] : 32'h0;
    assign instr_pc_o    = instr_valid_o ? bufPc_q[rdPtr_q]   : 32'h0;

    assign doPop         = instr_valid_o && instr_ready_i;
    assign postPushCount = count_q + 2'd1 - {1'b0, doPop};

    // Next-state logic for the fetch FSM and PC; redirect wins over everything.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        dropAddr_d = dropAddr_q;
        doPush     = 1'b0;
        doFlush    = 1'b0;
        case (state_q)
            IDLE: begin
                if (redirect_i) begin
                    pc_d    = redirectTarget;
                    doFlush = 1'b1;
                end else if (count_q < 2'd2) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (redirect_i) begin
                    pc_d    = redirectTarget;
                    doFlush = 1'b1;
                    if (imem_ack_i) begin
                        state_d = IDLE;
                    end else begin
                        state_d    = DROP;
                        dropAddr_d = pc_q;
                    end
                end else if (imem_ack_i) begin
                    doPush = 1'b1;
                    pc_d   = pc_q + 32'd4;
                    if (postPushCount < 2'd2) begin
                        state_d = REQ;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            DROP: begin
                // The buffer was flushed on entry and nothing is pushed here,
                // so a further redirect only needs to retarget the PC.
                if (redirect_i) begin
                    pc_d = redirectTarget;
                end
                if (imem_ack_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Buffer occupancy and pointer updates; a flush empties the buffer outright.
    always_comb begin
        count_d = count_q;
        rdPtr_d = rdPtr_q;
        wrPtr_d = wrPtr_q;
        if (doFlush) begin
            count_d = 2'd0;
            rdPtr_d = 1'b0;
            wrPtr_d = 1'b0;
        end else begin
            count_d = count_q + {1'b0, doPush} - {1'b0, doPop};
            rdPtr_d = rdPtr_q ^ doPop;
            wrPtr_d = wrPtr_q ^ doPush;
        end
    end

    // Control state registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            dropAddr_q <= RESET_PC;
            count_q    <= 2'd0;
            rdPtr_q    <= 1'b0;
            wrPtr_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            dropAddr_q <= dropAddr_d;
            count_q    <= count_d;
            rdPtr_q    <= rdPtr_d;
            wrPtr_q    <= wrPtr_d;
        end
    end

    // Buffer storage; contents are masked by the count, so no reset is needed.
    always_ff @(posedge clk_i) begin
        if (doPush) begin
            bufWord_q[wrPtr_q] <= imem_rdata_i;
            bufPc_q[wrPtr_q]   <= pc_q;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit: streaming, backpressure, redirects,
// PC wrap-around and reset during an outstanding request.
module tb_fetch_unit;

    logic        clk_i;
    logic        rst_ni;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i;
    logic [31:0] imem_rdata_i;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
    logic        instr_valid_o;
    logic        instr_ready_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;

    int checkCount;
    int errorCount;

    fetch_unit dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_ack_i    (imem_ack_i),
        .imem_rdata_i  (imem_rdata_i),
        .instr_o       (instr_o),
        .instr_pc_o    (instr_pc_o),
        .instr_valid_o (instr_valid_o),
        .instr_ready_i (instr_ready_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i)
    );

    // Free-running 10 ns clock.
    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    // Memory contents as a function of the word address.
    function automatic logic [31:0] memWord(input logic [31:0] addr);
        return (addr * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    // Compare one observed value against its hand-computed expectation.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    // Drive one cycle of inputs at the falling edge, with memory returning the
    // word at the currently presented address, then move to the next falling edge.
    task automatic applyStimulus(input logic rstN, input logic ack, input logic ready,
                                 input logic redir, input logic [31:0] redirPc);
        rst_ni        = rstN;
        imem_ack_i    = ack;
        instr_ready_i = ready;
        redirect_i    = redir;
        redirect_pc_i = redirPc;
        imem_rdata_i  = memWord(imem_addr_o);
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    initial begin
        checkCount    = 0;
        errorCount    = 0;
        rst_ni        = 1'b0;
        imem_ack_i    = 1'b0;
        imem_rdata_i  = 32'h0;
        instr_ready_i = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = 32'h0;
        @(negedge clk_i);

        // Reset state.
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        checkOutput("rst_req",   {31'h0, imem_req_o},    32'h0);
        checkOutput("rst_addr",  imem_addr_o,            32'h0);
        checkOutput("rst_valid", {31'h0, instr_valid_o}, 32'h0);
        checkOutput("rst_instr", instr_o,                32'h0);
        checkOutput("rst_ipc",   instr_pc_o,             32'h0);

        // Release: first request one cycle later at the reset PC.
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        checkOutput("first_req",   {31'h0, imem_req_o},    32'h1);
        checkOutput("first_addr",  imem_addr_o,            32'h0);
        checkOutput("first_valid", {31'h0, instr_valid_o}, 32'h0);

        // Streaming with same-cycle acks: one instruction per cycle.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
            checkOutput("stream_valid", {31'h0, instr_valid_o}, 32'h1);
            checkOutput("stream_ipc",   instr_pc_o,             32'(4 * i));
            checkOutput("stream_instr", instr_o,                memWord(32'(4 * i)));
            checkOutput("stream_addr",  imem_addr_o,            32'(4 * i + 4));
        end

        // Backpressure: buffer fills to two entries and fetching stops.
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        end
        checkOutput("bp_req",   {31'h0, imem_req_o},    32'h0);
        checkOutput("bp_valid", {31'h0, instr_valid_o}, 32'h1);
        checkOutput("bp_ipc",   instr_pc_o,             32'h0000_000C);
        checkOutput("bp_instr", instr_o,                memWord(32'h0000_000C));
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        checkOutput("bp_pop1_ipc", instr_pc_o,          32'h0000_0010);
        checkOutput("bp_pop1_req", {31'h0, imem_req_o}, 32'h0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        checkOutput("bp_pop2_valid", {31'h0, instr_valid_o}, 32'h0);
        checkOutput("bp_pop2_req",   {31'h0, imem_req_o},    32'h1);
        checkOutput("bp_pop2_addr",  imem_addr_o,            32'h0000_0014);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        checkOutput("bp_resume_ipc",   instr_pc_o, 32'h0000_0014);
        checkOutput("bp_resume_instr", instr_o,    memWord(32'h0000_0014));

        // Delayed ack with a redirect to 0x100 while waiting.
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("wait_valid", {31'h0, instr_valid_o}, 32'h0);
        checkOutput("wait_addr",  imem_addr_o,            32'h0000_0018);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0100);
        checkOutput("drop_req",  {31'h0, imem_req_o}, 32'h1);
        checkOutput("drop_addr", imem_addr_o,         32'h0000_0018);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("drop_hold_addr", imem_addr_o, 32'h0000_0018);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        checkOutput("drop_done_req",   {31'h0, imem_req_o},    32'h0);
        checkOutput("drop_done_valid", {31'h0, instr_valid_o}, 32'h0);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("redir_req",  {31'h0, imem_req_o}, 32'h1);
        checkOutput("redir_addr", imem_addr_o,         32'h0000_0100);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        checkOutput("redir_ipc",   instr_pc_o, 32'h0000_0100);
        checkOutput("redir_instr", instr_o,    memWord(32'h0000_0100));

        // Redirect to 0x203 coinciding with an ack and a decode pop.
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0203);
        checkOutput("coinc_valid", {31'h0, instr_valid_o}, 32'h0);
        checkOutput("coinc_instr", instr_o,                32'h0);
        checkOutput("coinc_req",   {31'h0, imem_req_o},    32'h0);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("coinc_addr", imem_addr_o, 32'h0000_0200);

        // PC wrap-around from 0xFFFF_FFFC to 0.
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        checkOutput("pre_wrap_ipc", instr_pc_o, 32'h0000_0200);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFD);
        checkOutput("pre_wrap_valid", {31'h0, instr_valid_o}, 32'h0);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("wrap_top_addr", imem_addr_o, 32'hFFFF_FFFC);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        checkOutput("wrap_ipc",  instr_pc_o,  32'hFFFF_FFFC);
        checkOutput("wrap_addr", imem_addr_o, 32'h0000_0000);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        checkOutput("post_wrap_addr", imem_addr_o, 32'h0000_0004);

        // Reset while a request is outstanding; the late ack is ignored.
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("mid_rst_req",   {31'h0, imem_req_o},    32'h0);
        checkOutput("mid_rst_valid", {31'h0, instr_valid_o}, 32'h0);
        checkOutput("mid_rst_addr",  imem_addr_o,            32'h0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        checkOutput("late_ack_valid", {31'h0, instr_valid_o}, 32'h0);
        checkOutput("late_ack_req",   {31'h0, imem_req_o},    32'h1);
        checkOutput("late_ack_addr",  imem_addr_o,            32'h0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        checkOutput("restart_ipc",   instr_pc_o, 32'h0);
        checkOutput("restart_instr", instr_o,    memWord(32'h0));

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, shall be the fetch address loaded on reset.
REQ-002 CLK  input  1  shall be the single clock; all state updates on its rising edge.
REQ-003 RST_N  input  1  shall be the synchronous, active-low reset, sampled on the rising edge of CLK.
REQ-004 IMEM_REQ  output  1  shall be the instruction-memory read request.
REQ-005 IMEM_ADDR  output  32  shall be the byte address of the requested word.
REQ-006 IMEM_ACK  input  1  shall mark the cycle in which IMEM_RDATA is valid and the request completes.
REQ-007 IMEM_RDATA  input  32  shall be the instruction word returned by memory.
REQ-008 INSTR  output  32  shall be the instruction word presented to the control unit (OP = INSTR[31:26]).
REQ-009 INSTR_PC  output  32  shall be the address from which INSTR was fetched.
REQ-010 INSTR_VALID  output  1  shall indicate INSTR/INSTR_PC hold a valid entry.
REQ-011 INSTR_READY  input  1  shall indicate decode accepts the entry this cycle.
REQ-012 REDIRECT  input  1  shall request a fetch redirect (taken BRANCH_EQ or JUMP).
REQ-013 REDIRECT_PC  input  32  shall be the redirect target.

Function
REQ-014 State machine shall have states IDLE, REQ, DROP; at most one memory request outstanding.
REQ-015 IMEM_REQ shall be 1 exactly in REQ and DROP; IMEM_ADDR shall stay constant while IMEM_REQ=1 until the IMEM_ACK cycle.
REQ-016 Instruction buffer shall be a 2-entry FIFO of {word, pc}; head drives INSTR/INSTR_PC; INSTR_VALID = (count != 0); INSTR and INSTR_PC shall read 0 when empty.
REQ-017 Pop shall occur on INSTR_VALID && INSTR_READY; push shall occur on a non-discarded IMEM_ACK; simultaneous push and pop shall leave count unchanged and preserve order.
REQ-018 IDLE -> REQ when count < 2 and REDIRECT=0, with IMEM_ADDR = PC; otherwise stay IDLE.
REQ-019 REQ with IMEM_ACK=1: push {IMEM_RDATA, PC}, PC <= PC + 4; stay REQ (back-to-back, IMEM_ADDR = new PC) if post-push count < 2, else go IDLE.
REQ-020 Latency: ACK in cycle N into an empty FIFO shall give INSTR_VALID=1 in cycle N+1; sustained throughput shall be one instruction per cycle with ACK returned the same cycle.
REQ-021 PC arithmetic shall be 32-bit modulo: 32'hFFFF_FFFC + 4 = 32'h0000_0000.
REQ-022 REDIRECT shall have highest priority: that cycle FIFO flushed (INSTR_VALID=0 next cycle), PC <= {REDIRECT_PC[31:2], 2'b00}, any push discarded.
REQ-023 REDIRECT in REQ without IMEM_ACK shall go to DROP; REDIRECT in REQ with IMEM_ACK shall discard the data and go IDLE.
REQ-024 DROP shall hold IMEM_REQ/IMEM_ADDR until IMEM_ACK, discard the data, then go IDLE; a further REDIRECT in DROP shall update PC only.
REQ-025 A decode handshake in a REDIRECT cycle shall be permitted; the popped entry is lost to the flush regardless.
REQ-026 IMEM_ACK sampled in IDLE shall be ignored.

Reset
REQ-027 While RST_N=0 at a clock edge: state IDLE, FIFO empty, PC = RESET_PC, IMEM_REQ=0, IMEM_ADDR=RESET_PC, INSTR=0, INSTR_PC=0, INSTR_VALID=0.
REQ-028 Reset mid-request shall abandon the request (IMEM_REQ=0 the cycle after reset); a late IMEM_ACK arriving in IDLE shall be ignored.
REQ-029 First request after reset release shall be issued one cycle later, at RESET_PC.

Verification
REQ-030 Reset release, memory ACKs every request same cycle, INSTR_READY=1 -> INSTR_PC sequence 0x0, 0x4, 0x8, ... one per cycle after first fill; words match memory.
REQ-031 INSTR_READY=0 for 10 cycles -> exactly 2 entries buffered, IMEM_REQ=0, no entry lost or duplicated when READY returns.
REQ-032 ACK delayed 3 cycles, REDIRECT to 0x100 during wait -> DROP held, returned word discarded, next request IMEM_ADDR=0x100.
REQ-033 REDIRECT_PC=0x203 coincident with ACK and full FIFO pop -> INSTR_VALID=0 next cycle, next IMEM_ADDR=0x200.
REQ-034 PC at 0xFFFF_FFFC -> following request at 0x0000_0000.
REQ-035 RST_N=0 while REQ outstanding, ACK arrives after reset -> ignored, FIFO empty, restart at RESET_PC.
